// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame constants, transmitter states and frame-bit helpers.
package ps2_pkg;

  localparam int         PS2_FRAME_BITS = 11;
  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BRK        = 8'hF0;

  typedef enum logic [1:0] {IDLE, FRAME, GAP} tx_state_t;

  // Which byte of a queued key event is currently on the wire.
  typedef enum logic [1:0] {SEG_EXT, SEG_BRK, SEG_CODE} seg_t;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // Bit idx of an 11-bit frame: start, data LSB first, odd parity, stop.
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    logic       v;
    logic [2:0] sel;
    v   = 1'b1;
    sel = 3'(idx - 4'd1);
    if (idx == 4'd0)      v = 1'b0;
    else if (idx <= 4'd8) v = b[sel];
    else if (idx == 4'd9) v = odd_parity(b);
    return v;
  endfunction

  function automatic seg_t first_seg(input logic ext, input logic brk);
    return ext ? SEG_EXT : (brk ? SEG_BRK : SEG_CODE);
  endfunction

  function automatic seg_t next_seg(input seg_t s, input logic brk);
    return (s == SEG_EXT && brk) ? SEG_BRK : SEG_CODE;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count and registered full/empty flags.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_n;
  logic             do_push;
  logic             do_pop;

  // Full is registered, so a pop in the same cycle never frees room for a write.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_n = count;
    if (do_push && !do_pop)      count_n = count + 1'b1;
    else if (!do_push && do_pop) count_n = count - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
      full  <= (count_n == CW'(DEPTH));
      empty <= (count_n == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ps2_key_tx.sv
// PS/2 keyboard emulator: queues key events and sends them as E0/F0-prefixed scan-code frames.
module ps2_key_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 2048,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CELLS  = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [7:0]                    KEY_CODE,
  input  logic                          KEY_EXT,
  input  logic                          KEY_BREAK,
  input  logic                          KEY_VALID,
  output logic                          KEY_READY,
  input  logic                          PS2_INHIBIT,
  output logic                          PS2_CLK_O,
  output logic                          PS2_DATA_O,
  output logic                          BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

  localparam int         CELL       = 2 * CLK_DIV;
  localparam int         PW         = $clog2(CELL);
  localparam int         GW         = $clog2(GAP_CELLS + 1);
  localparam logic [3:0] PARITY_IDX = 4'(PS2_FRAME_BITS - 2);
  localparam logic [3:0] LAST_IDX   = 4'(PS2_FRAME_BITS - 1);

  tx_state_t     state, state_n;
  seg_t          seg, seg_n;
  logic [PW-1:0] phase, phase_n;
  logic [3:0]    bit_idx, bit_n;
  logic [GW-1:0] cell_idx, cell_n;
  logic          retry, retry_n;
  logic          pop_pending, pop_n;
  logic          clk_n, data_n, busy_n;
  logic [9:0]    head;
  logic          fifo_full, fifo_empty;
  logic [7:0]    cur_byte;
  logic          cell_end;
  logic          abort;

  sync_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (CLK),
    .rst     (RESET),
    .push    (KEY_VALID),
    .wr_data ({KEY_EXT, KEY_BREAK, KEY_CODE}),
    .pop     (pop_pending),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (FIFO_COUNT)
  );

  assign KEY_READY = !fifo_full;
  assign cell_end  = (phase == PW'(CELL - 1));
  assign abort     = (state == FRAME) && PS2_INHIBIT && (bit_idx < PARITY_IDX);

  always_comb begin
    unique case (seg)
      SEG_EXT: cur_byte = PS2_EXT;
      SEG_BRK: cur_byte = PS2_BRK;
      default: cur_byte = head[7:0];
    endcase
  end

  always_comb begin
    state_n = state;
    seg_n   = seg;
    phase_n = phase;
    bit_n   = bit_idx;
    cell_n  = cell_idx;
    retry_n = retry;
    pop_n   = 1'b0;
    clk_n   = 1'b1;
    data_n  = 1'b1;
    busy_n  = (state != IDLE);

    unique case (state)
      IDLE: begin
        phase_n = '0;
        bit_n   = '0;
        cell_n  = '0;
        // The entry just finished is still at the head until its pop lands.
        if (!pop_pending && !fifo_empty && !PS2_INHIBIT) begin
          state_n = FRAME;
          seg_n   = first_seg(head[9], head[8]);
        end
      end
      FRAME: begin
        clk_n  = (phase < PW'(CLK_DIV));
        data_n = frame_bit(cur_byte, bit_idx);
        if (abort) begin
          state_n = GAP;
          phase_n = '0;
          bit_n   = '0;
          cell_n  = '0;
          retry_n = 1'b1;
          clk_n   = 1'b1;
          data_n  = 1'b1;
        end else if (cell_end) begin
          phase_n = '0;
          if (bit_idx == LAST_IDX) begin
            state_n = GAP;
            bit_n   = '0;
            cell_n  = '0;
          end else begin
            bit_n = bit_idx + 1'b1;
          end
        end else begin
          phase_n = phase + 1'b1;
        end
      end
      GAP: begin
        // The gap only counts down while the host leaves the clock line free.
        if (PS2_INHIBIT) begin
          phase_n = '0;
          cell_n  = '0;
        end else if (cell_end) begin
          phase_n = '0;
          if (cell_idx == GW'(GAP_CELLS - 1)) begin
            cell_n = '0;
            if (retry) begin
              retry_n = 1'b0;
              state_n = FRAME;
              seg_n   = first_seg(head[9], head[8]);
            end else if (seg == SEG_CODE) begin
              state_n = IDLE;
              pop_n   = 1'b1;
            end else begin
              state_n = FRAME;
              seg_n   = next_seg(seg, head[8]);
            end
          end else begin
            cell_n = cell_idx + 1'b1;
          end
        end else begin
          phase_n = phase + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      seg         <= SEG_CODE;
      phase       <= '0;
      bit_idx     <= '0;
      cell_idx    <= '0;
      retry       <= 1'b0;
      pop_pending <= 1'b0;
      PS2_CLK_O   <= 1'b1;
      PS2_DATA_O  <= 1'b1;
      BUSY        <= 1'b0;
    end else begin
      state       <= state_n;
      seg         <= seg_n;
      phase       <= phase_n;
      bit_idx     <= bit_n;
      cell_idx    <= cell_n;
      retry       <= retry_n;
      pop_pending <= pop_n;
      PS2_CLK_O   <= clk_n;
      PS2_DATA_O  <= data_n;
      BUSY        <= busy_n;
    end
  end

endmodule

// File: tb/tb_ps2_key_tx.sv
// Directed bench for ps2_key_tx: decodes frames at falling PS/2 clock edges and checks them.
module tb_ps2_key_tx;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] KEY_CODE;
  logic       KEY_EXT;
  logic       KEY_BREAK;
  logic       KEY_VALID;
  logic       KEY_READY;
  logic       PS2_INHIBIT;
  logic       PS2_CLK_O;
  logic       PS2_DATA_O;
  logic       BUSY;
  logic [2:0] FIFO_COUNT;

  int checks = 0;
  int errors = 0;

  ps2_key_tx #(.CLK_DIV(4), .FIFO_DEPTH(4), .GAP_CELLS(2)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .KEY_CODE    (KEY_CODE),
    .KEY_EXT     (KEY_EXT),
    .KEY_BREAK   (KEY_BREAK),
    .KEY_VALID   (KEY_VALID),
    .KEY_READY   (KEY_READY),
    .PS2_INHIBIT (PS2_INHIBIT),
    .PS2_CLK_O   (PS2_CLK_O),
    .PS2_DATA_O  (PS2_DATA_O),
    .BUSY        (BUSY),
    .FIFO_COUNT  (FIFO_COUNT)
  );

  always #5 CLK = ~CLK;

  // Host-side receiver: frames[i][0] is the start bit, [8:1] data, [9] parity, [10] stop.
  logic [10:0] frames[$];
  int          frame_time[$];
  logic [10:0] shreg;
  int          nbits = 0;
  int          idle_cyc = 0;
  int          fall_count = 0;
  int          cyc = 0;
  int          start_time = 0;
  logic        prev_clk = 1'b1;

  always @(posedge CLK) begin
    cyc++;
    if (RESET) begin
      nbits    = 0;
      idle_cyc = 0;
      prev_clk = 1'b1;
    end else begin
      if (prev_clk && !PS2_CLK_O) begin
        if (nbits == 0) start_time = cyc;
        shreg[nbits] = PS2_DATA_O;
        nbits++;
        fall_count++;
        idle_cyc = 0;
        if (nbits == 11) begin
          frames.push_back(shreg);
          frame_time.push_back(start_time);
          nbits = 0;
        end
      end else begin
        idle_cyc++;
        if (idle_cyc > 24) nbits = 0;
      end
      prev_clk = PS2_CLK_O;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] code, input logic ext, input logic brk);
    @(negedge CLK);
    KEY_CODE  = code;
    KEY_EXT   = ext;
    KEY_BREAK = brk;
    KEY_VALID = 1'b1;
    @(posedge CLK);
    #1;
    KEY_VALID = 1'b0;
  endtask

  task automatic waitIdle(input int budget, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < budget) begin
      @(posedge CLK);
      #1;
      n++;
      if (!BUSY && FIFO_COUNT == 3'd0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [10:0] getFrame(input int i);
    return (frames.size() > i) ? frames[i] : 11'h000;
  endfunction

  function automatic logic frameOk(input logic [10:0] f);
    return (f[0] == 1'b0) && (f[10] == 1'b1) && (f[9] == ~^f[8:1]);
  endfunction

  bit ok;
  int n;
  logic [2:0] exp_count [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
  logic       exp_ready [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    RESET       = 1'b1;
    KEY_CODE    = 8'h00;
    KEY_EXT     = 1'b0;
    KEY_BREAK   = 1'b0;
    KEY_VALID   = 1'b0;
    PS2_INHIBIT = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rst_clk", PS2_CLK_O, 1);
    checkOutput("rst_data", PS2_DATA_O, 1);
    checkOutput("rst_busy", BUSY, 0);
    checkOutput("rst_ready", KEY_READY, 1);
    checkOutput("rst_count", FIFO_COUNT, 0);
    @(negedge CLK);
    RESET = 1'b0;

    $display("[TB] single byte 1C");
    frames.delete();
    frame_time.delete();
    fall_count = 0;
    applyStimulus(8'h1C, 1'b0, 1'b0);
    checkOutput("count_after_push", FIFO_COUNT, 1);
    @(posedge CLK); #1;
    checkOutput("busy_t1", BUSY, 0);
    checkOutput("data_t1", PS2_DATA_O, 1);
    @(posedge CLK); #1;
    checkOutput("busy_t2", BUSY, 1);
    checkOutput("start_bit_t2", PS2_DATA_O, 0);
    n = 0;
    while (BUSY && n < 1000) begin
      @(posedge CLK); #1;
      n++;
    end
    checkOutput("busy_cycles", n, 104);
    checkOutput("count_at_busy_fall", FIFO_COUNT, 0);
    checkOutput("frames_1c", frames.size(), 1);
    checkOutput("frame_1c", getFrame(0), 11'b100_0011_1000);
    checkOutput("falls_1c", fall_count, 11);

    $display("[TB] extended break 75");
    frames.delete();
    frame_time.delete();
    applyStimulus(8'h75, 1'b1, 1'b1);
    waitIdle(1000, ok);
    checkOutput("idle_75", ok, 1);
    checkOutput("frames_75", frames.size(), 3);
    checkOutput("frame_e0", getFrame(0), 11'b101_1100_0000);
    checkOutput("frame_f0", getFrame(1), 11'b111_1110_0000);
    checkOutput("frame_75", getFrame(2), 11'b100_1110_1010);
    if (frame_time.size() == 3) begin
      checkOutput("spacing_0", frame_time[1] - frame_time[0], 104);
      checkOutput("spacing_1", frame_time[2] - frame_time[1], 104);
    end else begin
      checkOutput("spacing_frames", frame_time.size(), 3);
    end

    $display("[TB] queue overflow");
    frames.delete();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(8'h21 + 8'(i), 1'b0, 1'b0);
      checkOutput("ovf_count", FIFO_COUNT, 32'(exp_count[i]));
      checkOutput("ovf_ready", KEY_READY, 32'(exp_ready[i]));
    end
    waitIdle(3000, ok);
    checkOutput("idle_ovf", ok, 1);
    checkOutput("frames_ovf", frames.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("ovf_byte", getFrame(i) >> 1 & 11'hFF, 32'h21 + i);
      checkOutput("ovf_frame_ok", frameOk(getFrame(i)), 1);
    end

    $display("[TB] inhibit during F0");
    frames.delete();
    applyStimulus(8'h12, 1'b1, 1'b1);
    n = 0;
    while (!(frames.size() == 1 && nbits == 5) && n < 1000) begin
      @(posedge CLK); #1;
      n++;
    end
    checkOutput("inh_reach", n < 1000, 1);
    PS2_INHIBIT = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    checkOutput("inh_clk_high", PS2_CLK_O, 1);
    checkOutput("inh_data_high", PS2_DATA_O, 1);
    checkOutput("inh_count", FIFO_COUNT, 1);
    repeat (40) @(posedge CLK);
    #1;
    PS2_INHIBIT = 1'b0;
    checkOutput("inh_count_release", FIFO_COUNT, 1);
    waitIdle(2000, ok);
    checkOutput("idle_inh", ok, 1);
    checkOutput("frames_inh", frames.size(), 4);
    checkOutput("inh_e0_first", getFrame(0), 11'b101_1100_0000);
    checkOutput("inh_e0_again", getFrame(1), 11'b101_1100_0000);
    checkOutput("inh_f0", getFrame(2), 11'b111_1110_0000);
    checkOutput("inh_12", getFrame(3), 11'b110_0010_0100);

    $display("[TB] reset mid-frame");
    frames.delete();
    applyStimulus(8'h00, 1'b0, 1'b0);
    n = 0;
    while (!(nbits == 3 && PS2_CLK_O == 1'b0) && n < 500) begin
      @(posedge CLK); #1;
      n++;
    end
    checkOutput("rst_reach", n < 500, 1);
    #2;
    RESET = 1'b1;
    #1;
    checkOutput("rst_mid_clk", PS2_CLK_O, 1);
    checkOutput("rst_mid_data", PS2_DATA_O, 1);
    checkOutput("rst_mid_busy", BUSY, 0);
    checkOutput("rst_mid_count", FIFO_COUNT, 0);
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    frames.delete();
    applyStimulus(8'h5A, 1'b0, 1'b0);
    @(posedge CLK); #1;
    checkOutput("post_rst_t1_data", PS2_DATA_O, 1);
    @(posedge CLK); #1;
    checkOutput("post_rst_t2_data", PS2_DATA_O, 0);
    checkOutput("post_rst_t2_busy", BUSY, 1);
    waitIdle(1000, ok);
    checkOutput("idle_post_rst", ok, 1);
    checkOutput("frames_post_rst", frames.size(), 1);
    checkOutput("frame_5a", getFrame(0), 11'b110_1011_0100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
